// File: rtl/kbd_mailbox_arbiter.sv
// Keyboard character FIFO feeding a CPU-visible mailbox word, sharing the
// single data-memory write port with CPU stores (CPU always wins).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | nothing in flight; move to ARB once the FIFO holds a character
// ARB      | head character ready; issue on the first cycle with no CPU store
// WAIT_ACK | character delivered; wait for the CPU to store 0 to the mailbox
module kbd_mailbox_arbiter #(
  parameter int                ADDR_W     = 19,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] KBD_ADDR   = 19'hf00
) (
  input  logic                        CLOCK_50,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        key_valid,
  input  logic [7:0]                  key_ascii,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [31:0]                 cpu_wdata,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [31:0]                 mem_wdata,
  output logic                        kbd_pending,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ARB      = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [7:0]        fifo_q [FIFO_DEPTH];

  logic key_req;
  logic fifo_full;
  logic kbd_issue;
  logic push;
  logic pop;
  logic cpu_ack;

  assign key_req   = key_valid && (key_ascii != 8'h00);
  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  // ARB is only entered with a non-empty FIFO and only ARB pops, so the
  // head entry is always valid when the keyboard write is issued.
  assign kbd_issue = (state_q == ST_ARB) && !cpu_we && !clear;
  assign pop       = kbd_issue;
  assign push      = key_req && !clear && (!fifo_full || pop);
  assign cpu_ack   = cpu_we && (cpu_addr == KBD_ADDR) && (cpu_wdata[7:0] == 8'h00);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (count_q != '0) state_d = ST_ARB;
      ST_ARB:      if (kbd_issue) state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (cpu_ack) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (key_req && fifo_full && !pop) ovf_d = 1'b1;
    end
  end

  // Write-port mux: both sources see one cycle of latency; CPU never stalls.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (cpu_we) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_wdata;
    end else if (kbd_issue) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = KBD_ADDR;
      mem_wdata_d = {24'h0, fifo_q[head_q]};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge CLOCK_50) begin
    if (push) fifo_q[tail_q] <= key_ascii;
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign kbd_pending = (state_q == ST_WAIT_ACK);
  assign fifo_count  = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_kbd_mailbox_arbiter.sv
// Directed bench for kbd_mailbox_arbiter: each task drives one scenario and
// compares outputs against hand-computed values one cycle-step at a time.
module tb_kbd_mailbox_arbiter;

  localparam int ADDR_W = 19;

  logic              CLOCK_50 = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              key_valid;
  logic [7:0]        key_ascii;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              kbd_pending;
  logic [3:0]        fifo_count;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  kbd_mailbox_arbiter #(.ADDR_W(19), .FIFO_DEPTH(8), .KBD_ADDR(19'hf00)) dut (
    .CLOCK_50   (CLOCK_50),
    .rst_n      (rst_n),
    .clear      (clear),
    .key_valid  (key_valid),
    .key_ascii  (key_ascii),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .kbd_pending(kbd_pending),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push_key(input logic [7:0] c);
    key_valid = 1'b1;
    key_ascii = c;
    step();
    key_valid = 1'b0;
    key_ascii = 8'h00;
  endtask

  task automatic cpu_store(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    step();
    cpu_we    = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
    checks++; if (mem_addr !== 19'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (kbd_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0b want 0", kbd_pending); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
  endtask

  task automatic test_single_key();
    push_key(8'h41);
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_count1: got %0d want 1", fifo_count); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_c1: got %0b want 0", mem_we); end
    step();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_c2: got %0b want 0", mem_we); end
    checks++; if (kbd_pending !== 1'b0) begin errors++; $display("FAIL single_pend_c2: got %0b want 0", kbd_pending); end
    step();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL single_we_c3: got %0b want 1", mem_we); end
    checks++; if (mem_addr !== 19'hf00) begin errors++; $display("FAIL single_addr: got %h want f00", mem_addr); end
    checks++; if (mem_wdata !== 32'h41) begin errors++; $display("FAIL single_wdata: got %h want 41", mem_wdata); end
    checks++; if (kbd_pending !== 1'b1) begin errors++; $display("FAIL single_pend_c3: got %0b want 1", kbd_pending); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_count0: got %0d want 0", fifo_count); end
    step();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_c4: got %0b want 0", mem_we); end
    checks++; if (mem_addr !== 19'hf00) begin errors++; $display("FAIL single_addr_hold: got %h want f00", mem_addr); end
    checks++; if (kbd_pending !== 1'b1) begin errors++; $display("FAIL single_pend_c4: got %0b want 1", kbd_pending); end
  endtask

  task automatic test_ack_next();
    push_key(8'h42);
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL ack_queued: got %0d want 1", fifo_count); end
    checks++; if (kbd_pending !== 1'b1) begin errors++; $display("FAIL ack_pend_before: got %0b want 1", kbd_pending); end
    cpu_store(19'hf00, 32'h0);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL ack_fwd_we: got %0b want 1", mem_we); end
    checks++; if (mem_addr !== 19'hf00) begin errors++; $display("FAIL ack_fwd_addr: got %h want f00", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL ack_fwd_wdata: got %h want 0", mem_wdata); end
    checks++; if (kbd_pending !== 1'b0) begin errors++; $display("FAIL ack_pend_clr: got %0b want 0", kbd_pending); end
    step();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ack_gap_we: got %0b want 0", mem_we); end
    step();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL ack_next_we: got %0b want 1", mem_we); end
    checks++; if (mem_wdata !== 32'h42) begin errors++; $display("FAIL ack_next_wdata: got %h want 42", mem_wdata); end
    checks++; if (kbd_pending !== 1'b1) begin errors++; $display("FAIL ack_next_pend: got %0b want 1", kbd_pending); end
    cpu_store(19'hf00, 32'h0);
    step();
  endtask

  task automatic test_cpu_priority();
    push_key(8'h43);
    for (int i = 0; i < 10; i++) begin
      cpu_we    = 1'b1;
      cpu_addr  = 19'h100;
      cpu_wdata = 32'h1000 + i;
      step();
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 19'h100 || mem_wdata !== 32'h1000 + i) begin
        errors++;
        $display("FAIL prio_cpu_%0d: got we=%0b addr=%h data=%h want we=1 addr=100 data=%h",
                 i, mem_we, mem_addr, mem_wdata, 32'h1000 + i);
      end
    end
    cpu_we = 1'b0;
    step();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 19'hf00 || mem_wdata !== 32'h43) begin
      errors++; $display("FAIL prio_kbd: got we=%0b addr=%h data=%h want we=1 addr=f00 data=43", mem_we, mem_addr, mem_wdata);
    end
    checks++; if (kbd_pending !== 1'b1) begin errors++; $display("FAIL prio_pend: got %0b want 1", kbd_pending); end
    cpu_store(19'hf00, 32'h0);
    step();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) push_key(8'h61 + 8'(i));
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count8: got %0d want 8", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %0b want 0", overflow); end
    checks++; if (kbd_pending !== 1'b1) begin errors++; $display("FAIL ovf_pend: got %0b want 1", kbd_pending); end
    checks++; if (mem_wdata !== 32'h61) begin errors++; $display("FAIL ovf_first: got %h want 61", mem_wdata); end
    push_key(8'h6a);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b want 1", overflow); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count_hold: got %0d want 8", fifo_count); end
    for (int k = 0; k < 8; k++) begin
      cpu_store(19'hf00, 32'h0);
      step();
      step();
      checks++;
      if (mem_we !== 1'b1 || mem_wdata !== 32'h62 + k) begin
        errors++;
        $display("FAIL drain_%0d: got we=%0b data=%h want we=1 data=%h", k, mem_we, mem_wdata, 32'h62 + k);
      end
    end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL drain_empty: got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
    cpu_store(19'hf00, 32'h0);
    step();
  endtask

  task automatic test_clear();
    logic saw_write;
    for (int i = 0; i < 6; i++) push_key(8'h71 + 8'(i));
    checks++; if (fifo_count !== 4'd5) begin errors++; $display("FAIL clr_pre_count: got %0d want 5", fifo_count); end
    checks++; if (kbd_pending !== 1'b1) begin errors++; $display("FAIL clr_pre_pend: got %0b want 1", kbd_pending); end
    clear     = 1'b1;
    key_valid = 1'b1;
    key_ascii = 8'h70;
    cpu_we    = 1'b1;
    cpu_addr  = 19'h200;
    cpu_wdata = 32'hdead;
    step();
    clear     = 1'b0;
    key_valid = 1'b0;
    key_ascii = 8'h00;
    cpu_we    = 1'b0;
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: got %0b want 0", overflow); end
    checks++; if (kbd_pending !== 1'b0) begin errors++; $display("FAIL clr_pend: got %0b want 0", kbd_pending); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 19'h200 || mem_wdata !== 32'hdead) begin
      errors++; $display("FAIL clr_cpu_fwd: got we=%0b addr=%h data=%h want we=1 addr=200 data=dead", mem_we, mem_addr, mem_wdata);
    end
    saw_write = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_we === 1'b1) saw_write = 1'b1;
    end
    checks++; if (saw_write !== 1'b0) begin errors++; $display("FAIL clr_no_write: got %0b want 0", saw_write); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL clr_count_after: got %0d want 0", fifo_count); end
  endtask

  task automatic test_zero_and_nonack();
    push_key(8'h44);
    step();
    step();
    checks++; if (kbd_pending !== 1'b1 || mem_wdata !== 32'h44) begin
      errors++; $display("FAIL na_deliver: got pend=%0b data=%h want pend=1 data=44", kbd_pending, mem_wdata);
    end
    push_key(8'h00);
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL na_zero_key: got %0d want 0", fifo_count); end
    cpu_store(19'hf00, 32'h55);
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h55) begin
      errors++; $display("FAIL na_fwd: got we=%0b data=%h want we=1 data=55", mem_we, mem_wdata);
    end
    checks++; if (kbd_pending !== 1'b1) begin errors++; $display("FAIL na_pend_55: got %0b want 1", kbd_pending); end
    cpu_store(19'h100, 32'h0);
    step();
    checks++; if (kbd_pending !== 1'b1) begin errors++; $display("FAIL na_pend_other: got %0b want 1", kbd_pending); end
    cpu_store(19'hf00, 32'h0);
    checks++; if (kbd_pending !== 1'b0) begin errors++; $display("FAIL na_ack: got %0b want 0", kbd_pending); end
    step();
  endtask

  task automatic test_async_reset();
    push_key(8'h45);
    step();
    step();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL ar_pre_we: got %0b want 1", mem_we); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ar_we_drop: got %0b want 0", mem_we); end
    checks++; if (kbd_pending !== 1'b0) begin errors++; $display("FAIL ar_pend: got %0b want 0", kbd_pending); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL ar_wdata: got %h want 0", mem_wdata); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (mem_we !== 1'b0 || fifo_count !== 4'd0) begin
      errors++; $display("FAIL ar_after: got we=%0b count=%0d want we=0 count=0", mem_we, fifo_count);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    key_valid = 1'b0;
    key_ascii = 8'h00;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_reset();
    test_single_key();
    test_ack_next();
    test_cpu_priority();
    test_overflow();
    test_clear();
    test_zero_and_nonack();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kbd_mailbox_arbiter.md
Name: kbd_mailbox_arbiter

Overview:
- Buffers ASCII characters from the PS/2 keyboard decoder in a small FIFO.
- Delivers them one at a time into the CPU-visible keyboard mailbox word at KBD_ADDR.
- Arbitrates the single data-memory write port between CPU stores (always priority) and keyboard mailbox writes.
- Waits for the CPU to acknowledge each character (store of 0 to the mailbox) before delivering the next.

Parameters:
ADDR_W, 19, memory address width
FIFO_DEPTH, 8, character FIFO entries (power of two, >=2)
KBD_ADDR, 19'hf00, mailbox word address

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush: empties FIFO, clears overflow, returns FSM to IDLE
key_valid  in  1  one-cycle strobe, key_ascii valid
key_ascii  in  8  ASCII code from decoder
cpu_we  in  1  CPU store request
cpu_addr  in  ADDR_W  CPU store address
cpu_wdata  in  32  CPU store data
mem_we  out  1  write enable to data memory (registered)
mem_addr  out  ADDR_W  write address (registered)
mem_wdata  out  32  write data (registered)
kbd_pending  out  1  high while a delivered character awaits CPU acknowledge
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a character was dropped because FIFO was full

Behaviour:
- Reset (rst_n low, async): FIFO empty, pointers 0, state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, kbd_pending=0, fifo_count=0, overflow=0.
- Push: on key_valid with key_ascii!=0, write to tail. key_ascii==0 is ignored. Push is accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle.
- Full: when the FIFO is full and there is no same-cycle pop, the character is dropped and overflow is set. overflow clears only on reset or clear.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_count is registered and updates the cycle after push/pop. A simultaneous push and pop leaves the count unchanged.
- FSM states:
  - IDLE: if count>0, go to ARB.
  - ARB: if cpu_we=0 this cycle, register mem_we=1, mem_addr=KBD_ADDR, mem_wdata={24'b0,head}, pop head, go to WAIT_ACK. If cpu_we=1, stay in ARB; the keyboard is starved while the CPU keeps storing.
  - WAIT_ACK: kbd_pending=1. Leave to IDLE when cpu_we=1, cpu_addr=KBD_ADDR and cpu_wdata[7:0]=0. Any other CPU store, including a non-zero store to KBD_ADDR, does not acknowledge.
- Write-port mux (registered, latency 1 for both sources):
  - If cpu_we=1, the next cycle's mem_* equals the CPU's request.
  - Else, if the FSM issues in ARB, mem_* carries the keyboard write.
  - Else mem_we=0; mem_addr/mem_wdata hold their previous values.
  - A CPU store is never dropped or delayed.
- Minimum spacing between keyboard writes is 3 cycles (ARB -> WAIT_ACK -> ack -> IDLE -> ARB).
- clear (sync, highest priority after reset):
  - FIFO flushed, count=0, overflow=0, state=IDLE, kbd_pending=0.
  - A key_valid in the same cycle is dropped and does not set overflow.
  - A CPU store in the same cycle is still forwarded to mem_*.
- Reset asserted mid-delivery: the outstanding write is abandoned and mem_we drops asynchronously.
- The acknowledge store itself is also forwarded to memory, so the CPU-written 0 lands in the mailbox.

Test Plan:
- Reset then single key 0x41, no CPU activity -> key_valid at cycle 0; ARB at cycle 2; at cycle 3 mem_we=1, mem_addr=0xf00, mem_wdata=0x00000041; kbd_pending=1 from cycle 3; fifo_count back to 0.
- CPU store to 0xf00 with data 0 while pending -> same value appears on mem_* the next cycle; kbd_pending=0 a cycle later; a queued 0x42 is written 2 cycles after that.
- CPU holds cpu_we=1 (addr 0x100) for 10 cycles with 0x43 queued -> every mem_* cycle carries CPU data; the keyboard write appears on the first cycle after cpu_we falls.
- Push 9 keys (0x61..0x69) with no acknowledges, FIFO_DEPTH=8 -> 0x61 delivered; the FIFO then holds 0x62..0x69 (count=8) and overflow stays 0. A 10th key 0x6A is dropped and overflow=1. Draining with 8 acks yields 0x62..0x69 in order.
- clear asserted with count=5 and kbd_pending=1, plus key_valid 0x70 in the same cycle -> count=0, overflow=0, kbd_pending=0, and 0x70 is never written.
- key_ascii=0x00 strobe, and a non-zero CPU store (0x55) to 0xf00 during WAIT_ACK -> no push; pending remains 1.
